// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain
// clock/data pair. The sequence is clock inhibit, request-to-send, then
// device-clocked shifting of the frame, then an acknowledge check.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   tx_data      byte to send, sampled on an accepted tx_start
//   tx_start     one-cycle request, ignored while busy
//   tx_busy      high whenever the transmitter is not idle
//   tx_done      one-cycle pulse: byte sent and acknowledged
//   tx_err       one-cycle pulse: NACK or timeout
//   ps2_clk_oe   1 = pull the PS/2 clock line low
//   ps2_data_oe  1 = pull the PS/2 data line low
//   ps2_clk_in   PS/2 clock line as read at the pad
//   ps2_data_in  PS/2 data line as read at the pad
module ps2_host_tx #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned INHIBIT_CYCLES = 12_000,
    parameter int unsigned RTS_CYCLES     = 200,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned PW = $clog2(PHASE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    localparam logic [PW-1:0] PHASE_SAT    = PW'(PHASE_MAX);
    localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] RTS_LAST     = PW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TMO_SAT      = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);

    if (CLK_HZ == 0 || INHIBIT_CYCLES == 0 || RTS_CYCLES == 0 ||
        TIMEOUT_CYCLES == 0 || FILTER_LEN == 0) begin : g_bad_params
        $error("ps2_host_tx: timing parameters must be non-zero");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    // Input conditioning: index 0 = clock line, index 1 = data line.
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [FW-1:0] stab_cnt [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            sync1  <= {ps2_data_in, ps2_clk_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                // Filtered value follows only after FILTER_LEN consecutive
                // cycles of disagreement; any return resets the count.
                if (sync2[i] == filt[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == FILT_LAST) begin
                    filt[i]     <= sync2[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic clk_fall, filt_clk, filt_data;
    assign filt_clk  = filt[0];
    assign filt_data = filt[1];
    assign clk_fall  = filt_d[0] & ~filt[0];

    state_t        state, state_nxt;
    logic [9:0]    shift, shift_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [PW-1:0] phase_cnt, phase_cnt_nxt, phase_inc;
    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt, tmo_inc;
    logic          data_bit, data_bit_nxt;
    logic          done_nxt, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            tmo_cnt   <= '0;
            data_bit  <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            phase_cnt <= phase_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            data_bit  <= data_bit_nxt;
            tx_done   <= done_nxt;
            tx_err    <= err_nxt;
        end
    end

    assign phase_inc = (phase_cnt == PHASE_SAT) ? phase_cnt : phase_cnt + 1'b1;
    assign tmo_inc   = (tmo_cnt == TMO_SAT) ? tmo_cnt : tmo_cnt + 1'b1;

    // Abort has no resident cycle: the decision lands directly in IDLE with
    // tx_err registered, so busy drops in the same cycle the pulse appears.
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bit_cnt_nxt   = bit_cnt;
        phase_cnt_nxt = phase_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        data_bit_nxt  = data_bit;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        unique case (state)
            IDLE: begin
                // A request coinciding with the completion pulse is dropped.
                if (tx_start && !tx_done && !tx_err) begin
                    state_nxt     = INHIBIT;
                    phase_cnt_nxt = '0;
                    tmo_cnt_nxt   = '0;
                    bit_cnt_nxt   = '0;
                    shift_nxt     = {1'b1, ~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                if (phase_cnt == INHIBIT_LAST) begin
                    state_nxt     = RTS;
                    phase_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_inc;
                end
            end
            RTS: begin
                if (phase_cnt == RTS_LAST) begin
                    state_nxt    = SEND;
                    tmo_cnt_nxt  = '0;
                    bit_cnt_nxt  = '0;
                    data_bit_nxt = 1'b1;
                end else begin
                    phase_cnt_nxt = phase_inc;
                end
            end
            SEND: begin
                if (tmo_cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_inc;
                    if (clk_fall) begin
                        data_bit_nxt = ~shift[0];
                        shift_nxt    = {1'b0, shift[9:1]};
                        bit_cnt_nxt  = bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) begin
                            state_nxt = ACK;
                        end
                    end
                end
            end
            ACK: begin
                if (tmo_cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_inc;
                    if (clk_fall) begin
                        if (filt_data) begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end else begin
                            state_nxt = WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (tmo_cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_inc;
                    if (filt_clk && filt_data) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign tx_busy     = (state != IDLE);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == RTS);
    assign ps2_data_oe = (state == RTS) || ((state == SEND) && data_bit);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- randomized scoreboard bench for ps2_host_tx.
//
// A behavioural PS/2 device drives the open-drain pads, the stimulus
// process pushes expected outcomes and frames, and a monitor pops and
// compares on every tx_done / tx_err pulse.
module tb_ps2_host_tx;

    localparam int INH  = 300;
    localparam int RTSC = 20;
    localparam int TMO  = 3000;
    localparam int FL   = 8;
    localparam int LOW  = 20;
    localparam int HIGH = 25;

    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;
    localparam int M_RST    = 3;
    localparam int M_GLITCH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ        (100_000_000),
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTSC),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in)
    );

    typedef struct {
        logic [7:0] data;
        bit         want_done;
        bit         has_frame;
        logic [9:0] oe;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] cap_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Pin-level expectation: oe is the inverse of each frame bit, LSB first,
    // then an odd-parity bit, then a released stop bit.
    function automatic logic [9:0] model_oe(input logic [7:0] d);
        logic [9:0] r;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[i] ? 1'b0 : 1'b1;
            if (d[i]) ones++;
        end
        r[8] = (ones % 2 == 0) ? 1'b0 : 1'b1;
        r[9] = 1'b0;
        return r;
    endfunction

    // Monitor
    exp_t mon_e;
    logic prev_pulse = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_pulse) check("pulse_one_cycle", tx_done | tx_err, 0);
            prev_pulse = tx_done | tx_err;
            if (!rst && (tx_done || tx_err)) begin
                check("pulse_exclusive", tx_done & tx_err, 0);
                check("lines_released", {tx_busy, ps2_clk_oe, ps2_data_oe}, 0);
                check("exp_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("outcome_done", tx_done, mon_e.want_done);
                    check("outcome_err", tx_err, !mon_e.want_done);
                    if (mon_e.has_frame) begin
                        check("frame_captured", cap_q.size() != 0, 1);
                        if (cap_q.size() != 0) check("frame_bits", cap_q.pop_front(), mon_e.oe);
                    end
                end
            end
        end
    end

    // One transaction: issue the request, play the device side, then make
    // sure a start in the completion cycle is dropped.
    task automatic send(input logic [7:0] d, input int mode);
        exp_t       e;
        int         n;
        int         rise;
        logic [9:0] cap;
        e.data      = d;
        e.want_done = (mode == M_ACK) || (mode == M_GLITCH);
        e.has_frame = (mode != M_SILENT);
        e.oe        = model_oe(d);
        cap         = '0;
        exp_q.push_back(e);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check("accept_busy", tx_busy, 1);
        check("accept_clk_oe", ps2_clk_oe, 1);

        n = 0;
        rise = -1;
        while (ps2_clk_oe && n < INH + RTSC + 50) begin
            if (ps2_data_oe && rise < 0) rise = n;
            n++;
            @(negedge clk);
        end
        check("clk_oe_cycles", n, INH + RTSC);
        check("data_oe_rise", rise, INH);
        check("start_bit", ps2_data_oe, 1);

        if (mode == M_SILENT) begin
            n = 0;
            while (!tx_err && n < TMO + 50) begin
                n++;
                @(negedge clk);
            end
            check("timeout_cycles", n, TMO);
        end else begin
            repeat (10) @(negedge clk);
            for (int k = 1; k <= 11; k++) begin
                dev_clk = 1'b0;
                repeat (LOW) @(negedge clk);
                if (k <= 10) cap[k-1] = ps2_data_oe;
                if (mode == M_RST && k == 4) begin
                    @(posedge clk);
                    #2 rst = 1'b1;
                    #1;
                    check("rst_async_outputs",
                          {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 0);
                    exp_q.delete(exp_q.size() - 1);
                    dev_clk = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    break;
                end
                dev_clk = 1'b1;
                if (k == 10) dev_data = (mode == M_NACK);
                if (k == 11) begin
                    dev_data = 1'b1;
                end else if (mode == M_GLITCH && k == 5) begin
                    repeat (3) @(negedge clk);
                    dev_clk  = 1'b0;
                    tx_data  = ~d;
                    tx_start = 1'b1;
                    @(negedge clk);
                    tx_start = 1'b0;
                    repeat (4) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (HIGH - 8) @(negedge clk);
                end else begin
                    repeat (HIGH) @(negedge clk);
                end
                if (k == 10) cap_q.push_back(cap);
            end
        end

        n = 0;
        while (tx_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_drops", tx_busy, 0);
        if (mode == M_ACK || mode == M_GLITCH || mode == M_SILENT) begin
            tx_start = 1'b1;
            tx_data  = 8'($urandom);
            @(negedge clk);
            tx_start = 1'b0;
            check("start_in_pulse_cycle_ignored", tx_busy, 0);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", tx_busy, 0);
        check("rst_pulses", {tx_done, tx_err}, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", {tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 0);

        send(8'hED, M_ACK);
        send(8'h01, M_ACK);
        send(8'($urandom), M_NACK);
        send(8'($urandom), M_SILENT);
        send(8'($urandom), M_RST);
        send(8'hFF, M_ACK);
        send(8'($urandom), M_GLITCH);
        for (int i = 0; i < 12; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK);
        end

        repeat (20) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("cap_queue_drained", cap_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
